// File: rtl/sm83_pkg.sv
// Shared types and constants for the SM83 OAM DMA block.
package sm83_pkg;

   typedef logic [15:0] addr_t;
   typedef logic [7:0]  data_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      XFER  = 2'd2
   } dma_state_t;

   localparam addr_t OAM_BASE              = 16'hFE00;
   localparam int    OAM_DMA_LEN           = 160;
   localparam addr_t DMA_REG_ADDR_DEFAULT  = 16'hFF46;

   // Sources in echo RAM (E000-FFFF) alias work RAM 8 KiB lower.
   function automatic data_t echo_remap(input data_t hi);
      return (hi >= 8'hE0) ? data_t'(hi - 8'h20) : hi;
   endfunction

endpackage

// File: rtl/oam_dma_if.sv
// CPU register port and memory bus of the OAM DMA engine.
interface oam_dma_if;
   import sm83_pkg::*;

   logic  reg_wen;
   addr_t reg_addr;
   data_t reg_wdata;
   data_t reg_rdata;
   addr_t mem_r_addr;
   data_t mem_r_data;
   logic  mem_wen;
   addr_t mem_w_addr;
   data_t mem_w_data;
   logic  busy;
   logic  cpu_block;

   modport master (
      input  reg_wen, reg_addr, reg_wdata, mem_r_data,
      output reg_rdata, mem_r_addr, mem_wen, mem_w_addr, mem_w_data, busy, cpu_block
   );

   modport slave (
      output reg_wen, reg_addr, reg_wdata, mem_r_data,
      input  reg_rdata, mem_r_addr, mem_wen, mem_w_addr, mem_w_data, busy, cpu_block
   );

endinterface

// File: rtl/dma_pacer.sv
// Per-byte pacing counter: one period of CYCLES_PER_BYTE clocks, phase 0 first.
module dma_pacer #(
   parameter int CYCLES_PER_BYTE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic phase0,
   output logic period_end
);

   localparam int CW = $clog2(CYCLES_PER_BYTE);
   localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BYTE - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= period_end ? '0 : cnt + 1'b1;
      end
   end

   assign phase0     = (cnt == '0);
   assign period_end = (cnt == LAST);

endmodule

// File: rtl/oam_dma.sv
// OAM DMA engine: copies 160 bytes from {src_hi,00} to FE00, one byte per pacing period.
//
// state | meaning
// IDLE  | no transfer, bus outputs quiet
// START | one silent pacing period after a trigger write
// XFER  | bytes 0..159: phase 0 reads source, phase 1 writes OAM
module oam_dma
   import sm83_pkg::*;
#(
   parameter int    CYCLES_PER_BYTE = 4,
   parameter addr_t DMA_REG_ADDR    = DMA_REG_ADDR_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   oam_dma_if.master  bus
);

   dma_state_t state, state_nxt;
   data_t      src_hi;
   data_t      data_q;
   logic [7:0] idx;
   logic       ph1_q;
   logic       trig;
   logic       pace_en;
   logic       phase0;
   logic       period_end;
   logic       last_byte;
   addr_t      src_base;

   assign trig      = bus.reg_wen && (bus.reg_addr == DMA_REG_ADDR);
   assign pace_en   = (state != IDLE);
   assign last_byte = (idx == 8'(OAM_DMA_LEN - 1));
   assign src_base  = {echo_remap(src_hi), 8'h00};

   dma_pacer #(
      .CYCLES_PER_BYTE (CYCLES_PER_BYTE)
   ) u_pacer (
      .clk        (clk),
      .rst        (rst),
      .clear      (trig),
      .enable     (pace_en),
      .phase0     (phase0),
      .period_end (period_end)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (trig) begin
         state_nxt = START;
      end else begin
         case (state)
            IDLE:    state_nxt = IDLE;
            START:   if (period_end) state_nxt = XFER;
            XFER:    if (period_end && last_byte) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // ph1_q marks the clock after phase 0, so the write uses the byte just captured.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_hi <= 8'h00;
         data_q <= 8'h00;
         idx    <= 8'h00;
         ph1_q  <= 1'b0;
      end else begin
         if (trig) begin
            src_hi <= bus.reg_wdata;
            idx    <= 8'h00;
         end else if (state == XFER && period_end) begin
            idx <= last_byte ? 8'h00 : idx + 8'h01;
         end
         if (state == XFER && phase0) data_q <= bus.mem_r_data;
         ph1_q <= (state == XFER) && phase0 && !trig;
      end
   end

   always_comb begin
      bus.reg_rdata  = src_hi;
      bus.busy       = (state != IDLE);
      bus.cpu_block  = 1'b0;
      bus.mem_r_addr = 16'h0000;
      bus.mem_wen    = 1'b0;
      bus.mem_w_addr = 16'h0000;
      bus.mem_w_data = 8'h00;
      if (state == XFER) begin
         bus.cpu_block = 1'b1;
         if (phase0) bus.mem_r_addr = src_base + {8'h00, idx};
         if (ph1_q) begin
            bus.mem_wen    = 1'b1;
            bus.mem_w_addr = OAM_BASE + {8'h00, idx};
            bus.mem_w_data = data_q;
         end
      end
   end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: cycle-exact busy/write timing, remap, restart, reset, 2-clock pacing.
module tb_oam_dma;
   import sm83_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   oam_dma_if if4 ();
   oam_dma_if if2 ();

   logic [7:0] mem4 [0:65535];
   logic [7:0] mem2 [0:65535];

   assign if4.mem_r_data = mem4[if4.mem_r_addr];
   assign if2.mem_r_data = mem2[if2.mem_r_addr];

   oam_dma #(.CYCLES_PER_BYTE(4)) u4 (.clk(clk), .rst(rst), .bus(if4.master));
   oam_dma #(.CYCLES_PER_BYTE(2)) u2 (.clk(clk), .rst(rst), .bus(if2.master));

   int vec  = 0;
   int miss = 0;

   bit sel = 1'b0;
   int gap_exp = 4;
   int rel;
   int busy_n, busy_first, busy_last, cpub_n, rd_n, stray_n;
   int wr_n, wr_first, wr_last, bad_gap;
   int first_addr, first_data, last_addr, last_data;

   task automatic chk(input string tag, input int obs, input int exp);
      vec++;
      assert (obs === exp)
      else begin
         miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      busy_n = 0; busy_first = -1; busy_last = -1; cpub_n = 0; rd_n = 0; stray_n = 0;
      wr_n = 0; wr_first = -1; wr_last = -1; bad_gap = 0;
      first_addr = 0; first_data = 0; last_addr = 0; last_data = 0;
   endtask

   task automatic sample();
      logic b, cb, we;
      logic [15:0] ra, wa;
      logic [7:0] wd;
      if (sel) begin
         b = if2.busy; cb = if2.cpu_block; we = if2.mem_wen;
         ra = if2.mem_r_addr; wa = if2.mem_w_addr; wd = if2.mem_w_data;
      end else begin
         b = if4.busy; cb = if4.cpu_block; we = if4.mem_wen;
         ra = if4.mem_r_addr; wa = if4.mem_w_addr; wd = if4.mem_w_data;
      end
      if (b) begin
         busy_n++;
         if (busy_first < 0) busy_first = rel;
         busy_last = rel;
      end
      if (cb) cpub_n++;
      if (ra != 16'h0000) rd_n++;
      if (we) begin
         if (wr_n > 0 && (rel - wr_last) != gap_exp) bad_gap++;
         if (wr_n == 0) begin
            wr_first = rel; first_addr = int'(wa); first_data = int'(wd);
         end
         wr_last = rel; last_addr = int'(wa); last_data = int'(wd);
         wr_n++;
         if (sel) mem2[wa] = wd;
         else     mem4[wa] = wd;
      end else if (wa != 16'h0000 || wd != 8'h00) begin
         stray_n++;
      end
   endtask

   // Register write is sampled by the next rising edge (edge 0); this negedge is cycle 0.
   task automatic trig(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      if (sel) begin
         if2.reg_wen = 1'b1; if2.reg_addr = a; if2.reg_wdata = d;
      end else begin
         if4.reg_wen = 1'b1; if4.reg_addr = a; if4.reg_wdata = d;
      end
      rel = 0;
      sample();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if4.reg_wen = 1'b0;
         if2.reg_wen = 1'b0;
         rel++;
         sample();
      end
   endtask

   function automatic int oam_bad(input bit s, input logic [7:0] xv);
      int bad = 0;
      for (int i = 0; i < 160; i++) begin
         logic [15:0] a;
         logic [7:0]  e, g;
         a = 16'hFE00 + 16'(i);
         e = 8'(i) ^ xv;
         g = s ? mem2[a] : mem4[a];
         if (g !== e) bad++;
      end
      return bad;
   endfunction

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem4[i] = 8'h00;
         mem2[i] = 8'h00;
      end
      for (int i = 0; i < 160; i++) begin
         mem4[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
         mem4[16'hC300 + 16'(i)] = 8'(i) ^ 8'h33;
         mem4[16'hE300 + 16'(i)] = 8'hFF;
         mem4[16'hD000 + 16'(i)] = 8'(i) ^ 8'hA5;
         mem2[16'hC000 + 16'(i)] = 8'(i) ^ 8'hC3;
      end
      if4.reg_wen = 1'b0; if4.reg_addr = 16'h0000; if4.reg_wdata = 8'h00;
      if2.reg_wen = 1'b0; if2.reg_addr = 16'h0000; if2.reg_wdata = 8'h00;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_busy",      int'(if4.busy), 0);
      chk("rst_cpu_block", int'(if4.cpu_block), 0);
      chk("rst_mem_wen",   int'(if4.mem_wen), 0);
      chk("rst_rdata",     int'(if4.reg_rdata), 0);
      chk("rst_busy2",     int'(if2.busy), 0);
      rst = 1'b0;

      // basic transfer from C100
      sel = 1'b0; gap_exp = 4;
      clear_stats();
      trig(16'hFF46, 8'hC1);
      run(650);
      chk("t1_busy_n",     busy_n, 644);
      chk("t1_busy_first", busy_first, 1);
      chk("t1_busy_last",  busy_last, 644);
      chk("t1_cpu_block",  cpub_n, 640);
      chk("t1_wr_n",       wr_n, 160);
      chk("t1_wr_first",   wr_first, 6);
      chk("t1_first_addr", first_addr, 'hFE00);
      chk("t1_first_data", first_data, 'h5A);
      chk("t1_wr_last",    wr_last, 642);
      chk("t1_last_addr",  last_addr, 'hFE9F);
      chk("t1_gap",        bad_gap, 0);
      chk("t1_reads",      rd_n, 160);
      chk("t1_stray",      stray_n, 0);
      chk("t1_oam",        oam_bad(1'b0, 8'h5A), 0);
      chk("t1_rdata",      int'(if4.reg_rdata), 'hC1);

      // echo-RAM source
      clear_stats();
      trig(16'hFF46, 8'hE3);
      run(650);
      chk("t2_rdata", int'(if4.reg_rdata), 'hE3);
      chk("t2_wr_n",  wr_n, 160);
      chk("t2_oam",   oam_bad(1'b0, 8'h33), 0);

      // restart on byte 50's write clock
      clear_stats();
      trig(16'hFF46, 8'hC1);
      run(205);
      chk("t3_wr_before", wr_n, 50);
      trig(16'hFF46, 8'hD0);
      chk("t3_wr_n50",     wr_n, 51);
      chk("t3_addr50",     last_addr, 'hFE32);
      chk("t3_data50",     last_data, 'h68);
      clear_stats();
      run(650);
      chk("t3_wr_first", wr_first, 6);
      chk("t3_wr_n",     wr_n, 160);
      chk("t3_busy_last", busy_last, 644);
      chk("t3_oam",      oam_bad(1'b0, 8'hA5), 0);
      chk("t3_rdata",    int'(if4.reg_rdata), 'hD0);

      // reset during byte 80's write clock
      clear_stats();
      trig(16'hFF46, 8'hC1);
      run(325);
      @(negedge clk);
      if4.reg_wen = 1'b0;
      chk("t4_pre_wen",  int'(if4.mem_wen), 1);
      chk("t4_pre_addr", int'(if4.mem_w_addr), 'hFE50);
      rst = 1'b1;
      #1;
      chk("t4_wen",       int'(if4.mem_wen), 0);
      chk("t4_busy",      int'(if4.busy), 0);
      chk("t4_cpu_block", int'(if4.cpu_block), 0);
      chk("t4_w_addr",    int'(if4.mem_w_addr), 0);
      chk("t4_rdata",     int'(if4.reg_rdata), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      clear_stats();
      run(700);
      chk("t4_no_busy",   busy_n, 0);
      chk("t4_no_writes", wr_n, 0);
      chk("t4_no_reads",  rd_n, 0);

      // write to neighbouring register is ignored
      clear_stats();
      trig(16'hFF47, 8'h55);
      run(700);
      chk("t5_busy_n", busy_n, 0);
      chk("t5_wr_n",   wr_n, 0);
      chk("t5_rd_n",   rd_n, 0);
      chk("t5_stray",  stray_n, 0);
      chk("t5_rdata",  int'(if4.reg_rdata), 0);

      // two clocks per byte
      sel = 1'b1; gap_exp = 2;
      clear_stats();
      trig(16'hFF46, 8'hC0);
      run(330);
      chk("t6_busy_n",    busy_n, 322);
      chk("t6_busy_last", busy_last, 322);
      chk("t6_wr_n",      wr_n, 160);
      chk("t6_wr_first",  wr_first, 4);
      chk("t6_wr_last",   wr_last, 322);
      chk("t6_gap",       bad_gap, 0);
      chk("t6_oam",       oam_bad(1'b1, 8'hC3), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
